// File: rtl/vtisa_bus_responder.sv
// vtisa_bus_responder: byte-serial external memory bus responder with host preload/inspect port
module vtisa_bus_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_oe,
  output logic [7:0]        cpu_din,
  output logic              ack,
  output logic              drive_en,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              err_oor,
  output logic              err_timeout,
  output logic              err_contention
);
  localparam int WW = $clog2(WAIT_STATES + 2);
  localparam int TW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, ADDR_LO, WDATA, RWAIT} state_t;
  state_t state, state_n;
  logic [15:0] addr, rd_addr;
  logic we_q, rd_fire, wr_fire, to_fire, idle_tick, rd_oor, wr_oor, cpu_wr;
  logic [WW-1:0] wcnt;
  logic [TW-1:0] tcnt;
  logic [7:0] mem [2**ADDR_W];
  assign rd_addr = state == RWAIT ? addr : {addr[15:8], cpu_dout};
  assign rd_oor = (rd_addr >> ADDR_W) != 16'd0;
  assign wr_oor = (addr >> ADDR_W) != 16'd0;
  assign cpu_wr = wr_fire && !wr_oor;
  always_comb begin
    state_n = state;
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    to_fire = 1'b0;
    idle_tick = 1'b0;
    case (state)
      IDLE: state_n = req ? ADDR_LO : IDLE;
      ADDR_LO, WDATA: begin
        to_fire = !req && tcnt == TW'(TIMEOUT - 1);
        idle_tick = !req && !to_fire;
        rd_fire = req && state == ADDR_LO && !we_q && WAIT_STATES == 0;
        wr_fire = req && state == WDATA;
        state_n = (to_fire || rd_fire || wr_fire) ? IDLE : !req ? state : we_q ? WDATA : RWAIT;
      end
      RWAIT: begin
        rd_fire = wcnt == WW'(1);
        state_n = rd_fire ? IDLE : RWAIT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      we_q <= 1'b0;
      wcnt <= '0;
      tcnt <= '0;
      ack <= 1'b0;
      drive_en <= 1'b0;
      cpu_din <= '0;
      host_rdata <= '0;
      err_oor <= 1'b0;
      err_timeout <= 1'b0;
      err_contention <= 1'b0;
    end else begin
      state <= state_n;
      ack <= rd_fire || wr_fire;
      drive_en <= rd_fire;
      tcnt <= idle_tick ? tcnt + 1'b1 : '0;
      host_rdata <= mem[host_addr];
      if (state == IDLE && req) begin
        addr[15:8] <= cpu_dout;
        we_q <= we;
      end
      if (state == ADDR_LO && req) begin
        addr[7:0] <= cpu_dout;
        wcnt <= WW'(WAIT_STATES);
      end else if (state == RWAIT) begin
        wcnt <= wcnt - 1'b1;
      end
      if (rd_fire)
        cpu_din <= rd_oor ? 8'hFF : mem[rd_addr[ADDR_W-1:0]];
      if ((rd_fire && rd_oor) || (wr_fire && wr_oor))
        err_oor <= 1'b1;
      if (to_fire)
        err_timeout <= 1'b1;
      if (drive_en && cpu_oe)
        err_contention <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (cpu_wr)
      mem[addr[ADDR_W-1:0]] <= cpu_dout;
    if (host_we && !(cpu_wr && host_addr == addr[ADDR_W-1:0]))
      mem[host_addr] <= host_wdata;
  end
endmodule

// File: tb/tb_vtisa_bus_responder.sv
// tb_vtisa_bus_responder: directed self-checking bench for vtisa_bus_responder
module tb_vtisa_bus_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic we = 1'b0;
  logic [7:0] cpu_dout = '0;
  logic cpu_oe = 1'b0;
  logic host_we = 1'b0;
  logic [9:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic [7:0] din1, hr1, din0, hr0;
  logic ack1, drv1, eo1, et1, ec1, ack0, drv0, eo0, et0, ec0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  vtisa_bus_responder #(.ADDR_W(10), .WAIT_STATES(1), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .cpu_dout(cpu_dout), .cpu_oe(cpu_oe),
    .cpu_din(din1), .ack(ack1), .drive_en(drv1), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(hr1), .err_oor(eo1), .err_timeout(et1),
    .err_contention(ec1)
  );
  vtisa_bus_responder #(.ADDR_W(10), .WAIT_STATES(0), .TIMEOUT(15)) dut0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .cpu_dout(cpu_dout), .cpu_oe(cpu_oe),
    .cpu_din(din0), .ack(ack0), .drive_en(drv0), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(hr0), .err_oor(eo0), .err_timeout(et0),
    .err_contention(ec0)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic host_write(input logic [9:0] a, input logic [7:0] d);
    host_we = 1'b1;
    host_addr = a;
    host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (ack1 !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", ack1); end
    checks++; if (drv1 !== 1'b0) begin failures++; $display("FAIL rst_drive got=%b exp=0", drv1); end
    checks++; if (din1 !== 8'h00) begin failures++; $display("FAIL rst_din got=%h exp=00", din1); end
    checks++; if (hr1 !== 8'h00) begin failures++; $display("FAIL rst_hrdata got=%h exp=00", hr1); end
    checks++; if ({eo1, et1, ec1} !== 3'b000) begin failures++; $display("FAIL rst_err got=%b exp=000", {eo1, et1, ec1}); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_write;
    req = 1'b1; we = 1'b1; cpu_dout = 8'h01;
    tick();
    we = 1'b0; cpu_dout = 8'h23;
    tick();
    cpu_dout = 8'hA5;
    checks++; if (ack1 !== 1'b0) begin failures++; $display("FAIL wr_ack_early got=%b exp=0", ack1); end
    tick();
    req = 1'b0; host_addr = 10'h123;
    checks++; if (ack1 !== 1'b1) begin failures++; $display("FAIL wr_ack got=%b exp=1", ack1); end
    checks++; if (drv1 !== 1'b0) begin failures++; $display("FAIL wr_drive got=%b exp=0", drv1); end
    tick();
    checks++; if (ack1 !== 1'b0) begin failures++; $display("FAIL wr_ack_len got=%b exp=0", ack1); end
    checks++; if (hr1 !== 8'hA5) begin failures++; $display("FAIL wr_mem got=%h exp=a5", hr1); end
    checks++; if (hr0 !== 8'hA5) begin failures++; $display("FAIL wr_mem_ws0 got=%h exp=a5", hr0); end
  endtask
  task automatic test_read;
    host_write(10'h077, 8'h5A);
    req = 1'b1; we = 1'b0; cpu_dout = 8'h01;
    tick();
    cpu_dout = 8'h23;
    tick();
    req = 1'b0;
    checks++; if (ack1 !== 1'b0) begin failures++; $display("FAIL rd_ack_early got=%b exp=0", ack1); end
    checks++; if (ack0 !== 1'b1) begin failures++; $display("FAIL rd_ws0_ack got=%b exp=1", ack0); end
    checks++; if (drv0 !== 1'b1) begin failures++; $display("FAIL rd_ws0_drive got=%b exp=1", drv0); end
    checks++; if (din0 !== 8'hA5) begin failures++; $display("FAIL rd_ws0_din got=%h exp=a5", din0); end
    tick();
    checks++; if (ack1 !== 1'b1) begin failures++; $display("FAIL rd_ack got=%b exp=1", ack1); end
    checks++; if (drv1 !== 1'b1) begin failures++; $display("FAIL rd_drive got=%b exp=1", drv1); end
    checks++; if (din1 !== 8'hA5) begin failures++; $display("FAIL rd_din got=%h exp=a5", din1); end
    checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL rd_ws0_ack_len got=%b exp=0", ack0); end
    req = 1'b1; cpu_dout = 8'h00;
    tick();
    cpu_dout = 8'h77;
    tick();
    req = 1'b0;
    checks++; if (ack1 !== 1'b0) begin failures++; $display("FAIL b2b_ack_early got=%b exp=0", ack1); end
    tick();
    checks++; if (ack1 !== 1'b1) begin failures++; $display("FAIL b2b_ack got=%b exp=1", ack1); end
    checks++; if (din1 !== 8'h5A) begin failures++; $display("FAIL b2b_din got=%h exp=5a", din1); end
    tick();
    checks++; if ({ack1, drv1} !== 2'b00) begin failures++; $display("FAIL b2b_after got=%b exp=00", {ack1, drv1}); end
    checks++; if (din1 !== 8'h5A) begin failures++; $display("FAIL b2b_din_hold got=%h exp=5a", din1); end
  endtask
  task automatic test_oor;
    host_write(10'h100, 8'h77);
    checks++; if (eo1 !== 1'b0) begin failures++; $display("FAIL oor_pre got=%b exp=0", eo1); end
    req = 1'b1; we = 1'b0; cpu_dout = 8'h05;
    tick();
    cpu_dout = 8'h00;
    tick();
    req = 1'b0;
    checks++; if (ack1 !== 1'b0) begin failures++; $display("FAIL oor_rd_early got=%b exp=0", ack1); end
    checks++; if (eo0 !== 1'b1) begin failures++; $display("FAIL oor_ws0_err got=%b exp=1", eo0); end
    tick();
    checks++; if (ack1 !== 1'b1) begin failures++; $display("FAIL oor_rd_ack got=%b exp=1", ack1); end
    checks++; if (din1 !== 8'hFF) begin failures++; $display("FAIL oor_rd_din got=%h exp=ff", din1); end
    checks++; if (eo1 !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", eo1); end
    req = 1'b1; we = 1'b1; cpu_dout = 8'h05;
    tick();
    we = 1'b0; cpu_dout = 8'h00;
    tick();
    cpu_dout = 8'h99;
    tick();
    req = 1'b0; host_addr = 10'h100;
    checks++; if (ack1 !== 1'b1) begin failures++; $display("FAIL oor_wr_ack got=%b exp=1", ack1); end
    tick();
    checks++; if (hr1 !== 8'h77) begin failures++; $display("FAIL oor_wr_mem got=%h exp=77", hr1); end
  endtask
  task automatic test_timeout;
    logic seen;
    seen = 1'b0;
    req = 1'b1; we = 1'b0; cpu_dout = 8'h00;
    tick();
    req = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      seen = seen | ack1;
    end
    checks++; if (et1 !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", et1); end
    tick();
    seen = seen | ack1;
    checks++; if (et1 !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", et1); end
    checks++; if (et0 !== 1'b1) begin failures++; $display("FAIL to_ws0_err got=%b exp=1", et0); end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL to_no_ack got=%b exp=0", seen); end
    req = 1'b1; cpu_dout = 8'h01;
    tick();
    cpu_dout = 8'h23;
    tick();
    req = 1'b0;
    checks++; if (ack1 !== 1'b0) begin failures++; $display("FAIL to_rd_early got=%b exp=0", ack1); end
    tick();
    checks++; if (ack1 !== 1'b1) begin failures++; $display("FAIL to_rd_ack got=%b exp=1", ack1); end
    checks++; if (din1 !== 8'hA5) begin failures++; $display("FAIL to_rd_din got=%h exp=a5", din1); end
  endtask
  task automatic test_reset_mid_read;
    req = 1'b1; we = 1'b0; cpu_dout = 8'h01;
    tick();
    cpu_dout = 8'h23;
    tick();
    req = 1'b0; rst = 1'b1;
    tick();
    checks++; if ({ack1, drv1} !== 2'b00) begin failures++; $display("FAIL rmr_ack got=%b exp=00", {ack1, drv1}); end
    checks++; if ({eo1, et1, ec1} !== 3'b000) begin failures++; $display("FAIL rmr_err got=%b exp=000", {eo1, et1, ec1}); end
    checks++; if (din1 !== 8'h00) begin failures++; $display("FAIL rmr_din got=%h exp=00", din1); end
    rst = 1'b0;
    req = 1'b1; cpu_dout = 8'h01;
    tick();
    cpu_dout = 8'h23;
    tick();
    req = 1'b0;
    checks++; if (ack1 !== 1'b0) begin failures++; $display("FAIL rmr_rd_early got=%b exp=0", ack1); end
    tick();
    checks++; if (ack1 !== 1'b1) begin failures++; $display("FAIL rmr_rd_ack got=%b exp=1", ack1); end
    checks++; if (din1 !== 8'hA5) begin failures++; $display("FAIL rmr_rd_din got=%h exp=a5", din1); end
  endtask
  task automatic test_collision;
    req = 1'b1; we = 1'b1; cpu_dout = 8'h00;
    tick();
    we = 1'b0; cpu_dout = 8'h42;
    tick();
    cpu_dout = 8'h22; host_we = 1'b1; host_addr = 10'h042; host_wdata = 8'h11;
    tick();
    req = 1'b0; host_we = 1'b0;
    checks++; if (ack1 !== 1'b1) begin failures++; $display("FAIL col_ack got=%b exp=1", ack1); end
    tick();
    checks++; if (hr1 !== 8'h22) begin failures++; $display("FAIL col_same got=%h exp=22", hr1); end
    req = 1'b1; we = 1'b1; cpu_dout = 8'h00;
    tick();
    we = 1'b0; cpu_dout = 8'h44;
    tick();
    cpu_dout = 8'h55; host_we = 1'b1; host_addr = 10'h045; host_wdata = 8'h66;
    tick();
    req = 1'b0; host_we = 1'b0; host_addr = 10'h044;
    tick();
    checks++; if (hr1 !== 8'h55) begin failures++; $display("FAIL col_cpu got=%h exp=55", hr1); end
    host_addr = 10'h045;
    tick();
    checks++; if (hr1 !== 8'h66) begin failures++; $display("FAIL col_host got=%h exp=66", hr1); end
  endtask
  task automatic test_contention;
    cpu_oe = 1'b1;
    tick();
    cpu_oe = 1'b0;
    tick();
    checks++; if (ec1 !== 1'b0) begin failures++; $display("FAIL cont_idle got=%b exp=0", ec1); end
    req = 1'b1; we = 1'b0; cpu_dout = 8'h01;
    tick();
    cpu_dout = 8'h23;
    tick();
    req = 1'b0;
    tick();
    cpu_oe = 1'b1;
    checks++; if (drv1 !== 1'b1) begin failures++; $display("FAIL cont_drive got=%b exp=1", drv1); end
    checks++; if (ec1 !== 1'b0) begin failures++; $display("FAIL cont_pre got=%b exp=0", ec1); end
    tick();
    cpu_oe = 1'b0;
    checks++; if (ec1 !== 1'b1) begin failures++; $display("FAIL cont_err got=%b exp=1", ec1); end
    checks++; if (ec0 !== 1'b0) begin failures++; $display("FAIL cont_ws0 got=%b exp=0", ec0); end
    tick();
    checks++; if (ec1 !== 1'b1) begin failures++; $display("FAIL cont_sticky got=%b exp=1", ec1); end
  endtask
  initial begin
    test_reset();
    test_write();
    test_read();
    test_oor();
    test_timeout();
    test_reset_mid_read();
    test_collision();
    test_contention();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vtisa_bus_responder.md
Name: vtisa_bus_responder

Overview:
- Host-side responder for the CPU's byte-serial external memory bus. The CPU is the initiator; this block answers its requests from a local byte memory.
- Used in the simulation harness and in the FPGA bring-up build, wired to the CPU's uio pins.
- Also has a host port for preloading programs and inspecting memory.

Parameters:
- ADDR_W, 10: memory address width; depth = 2^ADDR_W bytes.
- WAIT_STATES, 1: cycles inserted between address-low acceptance and read data.
- TIMEOUT, 15: idle-request cycles tolerated mid-transaction before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  1  CPU byte strobe; one byte is accepted per cycle while high.
- we  in  1  CPU write flag; sampled with the address-high byte.
- cpu_dout  in  8  CPU-driven bus byte (uio_out).
- cpu_oe  in  1  CPU bus-drive enable (any uio_oe bit).
- cpu_din  out  8  read data to CPU (uio_in).
- ack  out  1  one-cycle transaction completion.
- drive_en  out  1  responder drives the bus; high only in read-ack cycle.
- host_we  in  1  host write strobe.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  8  host write data.
- host_rdata  out  8  host read data, registered, 1-cycle latency.
- err_oor  out  1  sticky: CPU accessed an address >= 2^ADDR_W.
- err_timeout  out  1  sticky: transaction aborted by timeout.
- err_contention  out  1  sticky: cpu_oe was high while drive_en was high.

Behaviour:
- Reset, synchronous, wins over everything:
  - state IDLE; ack, drive_en, cpu_din, host_rdata, all err_* = 0; counters = 0.
  - Memory contents are not reset.
- States: IDLE, ADDR_LO, WDATA, RWAIT.
- IDLE: if req=1, latch cpu_dout into addr[15:8] and latch we, then go to ADDR_LO. Otherwise stay.
- ADDR_LO: if req=1, latch cpu_dout into addr[7:0].
  - If we=1, go to WDATA.
  - If we=0 and WAIT_STATES=0, do the read and return to IDLE.
  - If we=0 and WAIT_STATES>0, load the wait counter with WAIT_STATES and go to RWAIT.
- WDATA: if req=1, write mem[addr] = cpu_dout at the clock edge. Set ack=1 for the next cycle and return to IDLE.
- RWAIT: req is ignored. Decrement the counter each cycle. When it hits 0, register cpu_din = mem[addr], set ack=1 and drive_en=1 for the next cycle, and return to IDLE.
- Read latency:
  - Address-low accepted in cycle T; ack/cpu_din/drive_en are valid in cycle T+1+WAIT_STATES.
  - Write: data accepted in cycle T; ack valid in T+1.
- ack and drive_en last exactly one cycle. cpu_din holds its last value afterwards.
- Back-to-back transactions: req=1 during an ack cycle is accepted as the next address-high byte, since the block is already in IDLE.
- Timeout (ADDR_LO or WDATA only):
  - A counter counts consecutive req=0 cycles and clears on any req=1.
  - When it reaches TIMEOUT, return to IDLE, set err_timeout, and do not pulse ack. No memory write occurs.
- Out of range: if addr[15:ADDR_W] != 0:
  - a read returns 8'hFF, with ack timing unchanged;
  - a write is dropped, but ack still pulses;
  - err_oor is set in the ack cycle.
- Contention: err_contention is set in any cycle where drive_en=1 and cpu_oe=1.
- Host port:
  - Usable in any state.
  - host_rdata = mem[host_addr] one cycle after the request.
  - If the host and CPU write the same address in the same cycle, the CPU write wins and the host write is dropped. Different addresses both complete.
- Sticky errors clear only on rst.

Test Plan:
- Write, default params: CPU writes 0xA5 to 0x0123 (req high for 3 cycles: 0x01, 0x23, 0xA5) -> ack=1 exactly in the 4th cycle; mem[0x123]=0xA5 via host_rdata.
- Read: CPU reads 0x0123 -> address-low in cycle T, ack=1, drive_en=1, cpu_din=0xA5 in T+2.
  - Repeat with WAIT_STATES=0 -> ack in T+1.
  - Back-to-back read issued in the ack cycle -> accepted.
- Out of range: read of 0x0500 (ADDR_W=10) -> cpu_din=0xFF, ack in T+2, err_oor=1.
  - Write of 0x0500 -> ack pulses, mem unchanged.
- Timeout: send address-high 0x00, then hold req=0 -> after 15 idle cycles state returns to IDLE, err_timeout=1, no ack.
  - A new read of 0x0123 still returns 0xA5.
- Reset mid-read: rst=1 during RWAIT -> next cycle ack=0, drive_en=0, err_*=0, state IDLE; mem[0x123] still 0xA5.
- Host collision: host_we writes 0x11 and CPU WDATA writes 0x22 to 0x0042 in the same cycle -> mem[0x042]=0x22.
  - Assert cpu_oe=1 during a read ack -> err_contention=1.
